int_rs_issue: RTL
=================

# int_rs_issue

Integer reservation station and issue select for the integer pipe. It accepts renamed ALU micro-ops from dispatch and holds them in a small entry array. Each entry snoops the CDB to capture missing source operands. Every cycle it issues the oldest entry whose sources are both available, as `int_rs_reg`/`int_rs_reg_valid`, to the ALU functional unit. That unit broadcasts its result one cycle later on the same CDB this block snoops.

## Interface
Parameters:
- `INT_RS_DEPTH`, 8: number of entries; power of two, 2–16.
- `ROB_IDX_W`, `PRF_IDX_W`: widths of `rob_id` and `*_phy`; taken from `cpu_params`.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: active-low synchronous reset (asserted when 0).
- `flush` in 1: pipeline flush; invalidates all entries.
- `dispatch_valid` in 1: a micro-op is offered.
- `dispatch_ready` out 1: at least one entry is free.
- `dispatch_entry` in `int_rs_entry_t`: `rob_id`, `rd_arch`, `rd_phy`, `pc`, `imm_packed`, `fu_opcode`, `op1_sel`, `op2_sel`, `rs1_phy`, `rs1_rdy`, `rs1_value`, `rs2_phy`, `rs2_rdy`, `rs2_value`.
- `cdb` `cdb_itf.rs`: snooped inputs `valid`, `rd_phy`, `rd_value`.
- `fu_ready` in 1: the FU accepts an issue this cycle.
- `int_rs_reg` out `int_rs_reg_t`: issued micro-op, with operands resolved to values.
- `int_rs_reg_valid` out 1: `int_rs_reg` is meaningful this cycle.

## Operation
- **Entry state:** `valid`, plus the `dispatch_entry` fields. `rs*_rdy`/`rs*_value` are the captured operand state.
- **Dispatch write:**
  - Fires when `dispatch_valid && dispatch_ready && !flush`.
  - The lowest-index free entry is written.
  - `dispatch_ready = !(&valid)`; it is combinational from registered state and ignores a same-cycle issue.
- **Wakeup:** on `cdb.valid`, each valid entry compares `rs1_phy` and `rs2_phy` (when the matching `rdy` is 0) against `cdb.rd_phy`. On a match it sets `rdy=1` and `value=cdb.rd_value`.
- **Dispatch/CDB bypass:** the same tag comparison is applied to the operand being written by dispatch in the same cycle, so a broadcast in the dispatch cycle is never lost.
- **Operands not read from the PRF:** an operand not used by `op1_sel`/`op2_sel` is marked ready by dispatch (`rdy=1`). This block does not decode `op*_sel`.
- **Age tracking:**
  - `INT_RS_DEPTH`×`INT_RS_DEPTH` age matrix; `older[i][j]=1` means entry i is older than entry j.
  - On dispatch into slot k: column k is set for all currently valid rows; row k is cleared.
- **Select:**
  - Candidate = `valid && rs1_rdy && rs2_rdy`.
  - The winner is the candidate with no older candidate.
  - Readiness comes from registered state only; an entry woken this cycle becomes eligible next cycle.
- **Issue:**
  - `int_rs_reg_valid = any candidate`, independent of `fu_ready`.
  - `int_rs_reg` is the winner's fields; it is all-zero when there is no candidate.
  - The winner's `valid` clears on the edge where `int_rs_reg_valid && fu_ready`.
  - When `fu_ready=0`, nothing is dequeued.
- **Flush:**
  - All `valid` bits clear on the next edge.
  - A dispatch offered in the flush cycle is dropped.
  - No issue is dequeued in the flush cycle.
- **Reset (rst=0):**
  - All `valid`=0 and the age matrix =0.
  - Outputs after reset: `dispatch_ready`=1, `int_rs_reg_valid`=0, `int_rs_reg`='0.
  - Reset during operation discards all entries in one cycle; state is not otherwise defined.

## Timing
- **Dispatch-to-issue latency:**
  - Dispatch accepted at edge t with both sources ready → `int_rs_reg_valid` in cycle t+1.
  - The FU result is on the CDB in cycle t+2.
- **Wakeup-to-issue latency:** CDB broadcast in cycle t → the dependent entry is eligible in cycle t+1.
  - Back-to-back dependent ALU ops therefore have a 2-cycle spacing.
- **Full:**
  - With all entries valid, `dispatch_ready`=0 for that cycle, even if an issue frees an entry.
  - `dispatch_ready` returns to 1 the cycle after the free.
- **Simultaneous events:**
  - Issue and dispatch in one cycle are both performed.
  - A dispatch may never overwrite the entry being freed.
- **Oldest-first:** two candidates become eligible in the same cycle → the older issues first; the other issues the next cycle, given `fu_ready`.
- **Output path:** the output is combinational from registered state; there is no combinational path from the `dispatch_*` or `cdb` inputs to the outputs.

## Structure
- **Shared package:** `int_rs_types` holds `int_rs_entry_t` (extended with `rs*_phy`/`rdy`), `int_rs_reg_t` and the `OP1_*`/`OP2_*`/`ALU_*` enums.
- **Shared parameters:** `cpu_params` holds `INT_RS_DEPTH`, `ROB_IDX_W` and `PRF_IDX_W`.
- **Sub-module:** one, `rs_age_select`. It holds the age matrix, takes the candidate vector and the dispatch slot, and produces a one-hot winner. It is reusable by the other reservation stations.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles → `dispatch_ready`=1, `int_rs_reg_valid`=0, `int_rs_reg`=0.
- **Dispatch of a ready op:** dispatch ADD (`rs1_value`=5, `rs2_value`=7, both `rdy`) at t → in cycle t+1, `int_rs_reg_valid`=1, `rob_id` matches, values 5/7; the entry is freed.
- **Wakeup and bypass:**
  - Dispatch an op with `rs2_phy`=12 not ready; broadcast CDB `rd_phy`=12, value `0xDEADBEEF`, at t+3 → issue in t+4 with `rs2_value` `0xDEADBEEF`.
  - Repeat with the broadcast in the same cycle as dispatch → issue at t+1.
- **Age order and back-pressure:**
  - Dispatch op A (waiting on p3), then op B (ready); B issues first.
  - Wake A and B in the same cycle → A issues before B.
  - Hold `fu_ready`=0 → the same winner is held with no dequeue.
- **Full:**
  - Fill 8 blocked entries → `dispatch_ready`=0.
  - Wake one; it issues → `dispatch_ready`=1 the next cycle; a 9th dispatch lands in the freed slot.
- **Flush:**
  - With 5 entries valid, assert `flush` alongside a dispatch → next cycle no entries, `int_rs_reg_valid`=0; the dropped op never issues.
  - Repeat with `rst` low → same outcome.

Source files
------------

// File: rtl/cpu_params.sv
// Core-wide sizing parameters shared by the reservation stations and the CDB.
package cpu_params;
  localparam int INT_RS_DEPTH = 8;
  localparam int ROB_IDX_W    = 5;
  localparam int PRF_IDX_W    = 6;
  localparam int XLEN         = 32;
endpackage

// File: rtl/int_rs_types.sv
// Integer reservation station entry/issue types and the ALU operand/opcode enums.
package int_rs_types;
  import cpu_params::*;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_PC   = 2'd1,
    OP1_ZERO = 2'd2
  } op1_sel_t;

  typedef enum logic [1:0] {
    OP2_RS2 = 2'd0,
    OP2_IMM = 2'd1,
    OP2_FOUR = 2'd2
  } op2_sel_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_id;
    logic [4:0]           rd_arch;
    logic [PRF_IDX_W-1:0] rd_phy;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      imm_packed;
    alu_op_t              fu_opcode;
    op1_sel_t             op1_sel;
    op2_sel_t             op2_sel;
    logic [PRF_IDX_W-1:0] rs1_phy;
    logic                 rs1_rdy;
    logic [XLEN-1:0]      rs1_value;
    logic [PRF_IDX_W-1:0] rs2_phy;
    logic                 rs2_rdy;
    logic [XLEN-1:0]      rs2_value;
  } int_rs_entry_t;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_id;
    logic [4:0]           rd_arch;
    logic [PRF_IDX_W-1:0] rd_phy;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      imm_packed;
    alu_op_t              fu_opcode;
    op1_sel_t             op1_sel;
    op2_sel_t             op2_sel;
    logic [XLEN-1:0]      rs1_value;
    logic [XLEN-1:0]      rs2_value;
  } int_rs_reg_t;

  // Drop the tag/ready bookkeeping once both operands are resolved values.
  function automatic int_rs_reg_t to_reg(int_rs_entry_t e);
    int_rs_reg_t r;
    r.rob_id     = e.rob_id;
    r.rd_arch    = e.rd_arch;
    r.rd_phy     = e.rd_phy;
    r.pc         = e.pc;
    r.imm_packed = e.imm_packed;
    r.fu_opcode  = e.fu_opcode;
    r.op1_sel    = e.op1_sel;
    r.op2_sel    = e.op2_sel;
    r.rs1_value  = e.rs1_value;
    r.rs2_value  = e.rs2_value;
    return r;
  endfunction
endpackage

// File: rtl/cdb_itf.sv
// Common data bus: one physical-register writeback broadcast per cycle.
interface cdb_itf;
  import cpu_params::*;
  logic                 valid;
  logic [PRF_IDX_W-1:0] rd_phy;
  logic [XLEN-1:0]      rd_value;
  modport rs (input valid, rd_phy, rd_value);
  modport fu (output valid, rd_phy, rd_value);
endinterface

// File: rtl/rs_age_select.sv
// Age-matrix oldest-first selector, reusable by any reservation station.
module rs_age_select #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  input  logic [DEPTH-1:0] alloc_slot,
  input  logic [DEPTH-1:0] valid,
  input  logic [DEPTH-1:0] cand,
  output logic [DEPTH-1:0] winner
);

  // older[i][j] = 1 means entry i was allocated before entry j
  logic [DEPTH-1:0] older [DEPTH];

  // A new entry is younger than every live entry; its own row starts empty
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else if (alloc) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_slot[i]) older[i] <= '0;
        else if (valid[i]) older[i] <= older[i] | alloc_slot;
      end
    end
  end

  // A candidate wins when no other candidate is older than it
  always_comb begin
    winner = '0;
    for (int i = 0; i < DEPTH; i++) begin
      winner[i] = cand[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (cand[j] && older[j][i]) winner[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/int_rs_issue.sv
// Integer reservation station: holds renamed ALU ops, snoops the CDB, issues oldest ready.
module int_rs_issue
  import int_rs_types::*;
#(
  parameter int INT_RS_DEPTH = cpu_params::INT_RS_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          dispatch_valid,
  output logic          dispatch_ready,
  input  int_rs_entry_t dispatch_entry,
  cdb_itf.rs            cdb,
  input  logic          fu_ready,
  output int_rs_reg_t   int_rs_reg,
  output logic          int_rs_reg_valid
);

  int_rs_entry_t           entries [INT_RS_DEPTH];
  logic [INT_RS_DEPTH-1:0] valid;
  logic [INT_RS_DEPTH-1:0] cand;
  logic [INT_RS_DEPTH-1:0] winner;
  logic [INT_RS_DEPTH-1:0] free_slot;
  int_rs_entry_t           wr_entry;
  logic                    dispatch_fire;
  logic                    issue_fire;

  // Full check looks only at registered valids, so a same-cycle issue never frees room
  assign dispatch_ready = ~&valid;
  assign dispatch_fire  = dispatch_valid && dispatch_ready && !flush;
  assign issue_fire     = int_rs_reg_valid && fu_ready && !flush;

  // Lowest-index free entry, one-hot
  always_comb begin
    free_slot = '0;
    for (int i = INT_RS_DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_slot    = '0;
        free_slot[i] = 1'b1;
      end
    end
  end

  // Entries whose operands were both captured by the previous edge
  always_comb begin
    cand = '0;
    for (int i = 0; i < INT_RS_DEPTH; i++) begin
      cand[i] = valid[i] && entries[i].rs1_rdy && entries[i].rs2_rdy;
    end
  end

  // Apply a same-cycle broadcast to the incoming op so the wakeup is not lost
  always_comb begin
    wr_entry = dispatch_entry;
    if (cdb.valid && !dispatch_entry.rs1_rdy && dispatch_entry.rs1_phy == cdb.rd_phy) begin
      wr_entry.rs1_rdy   = 1'b1;
      wr_entry.rs1_value = cdb.rd_value;
    end
    if (cdb.valid && !dispatch_entry.rs2_rdy && dispatch_entry.rs2_phy == cdb.rd_phy) begin
      wr_entry.rs2_rdy   = 1'b1;
      wr_entry.rs2_value = cdb.rd_value;
    end
  end

  rs_age_select #(
    .DEPTH(INT_RS_DEPTH)
  ) u_age_select (
    .clk        (clk),
    .rst        (rst),
    .alloc      (dispatch_fire),
    .alloc_slot (free_slot),
    .valid      (valid),
    .cand       (cand),
    .winner     (winner)
  );

  // Issue port: winner's fields, or all-zero when nothing is ready
  always_comb begin
    int_rs_reg       = '0;
    int_rs_reg_valid = |cand;
    for (int i = 0; i < INT_RS_DEPTH; i++) begin
      if (winner[i]) int_rs_reg = to_reg(entries[i]);
    end
  end

  // Occupancy: free the issued winner and claim the dispatch slot (never the same entry)
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else begin
      valid <= (valid & ~({INT_RS_DEPTH{issue_fire}} & winner))
             | ({INT_RS_DEPTH{dispatch_fire}} & free_slot);
    end
  end

  // Entry payload: dispatch write, otherwise CDB operand capture on tag match
  always_ff @(posedge clk) begin
    for (int i = 0; i < INT_RS_DEPTH; i++) begin
      if (dispatch_fire && free_slot[i]) begin
        entries[i] <= wr_entry;
      end else if (valid[i] && cdb.valid) begin
        if (!entries[i].rs1_rdy && entries[i].rs1_phy == cdb.rd_phy) begin
          entries[i].rs1_rdy   <= 1'b1;
          entries[i].rs1_value <= cdb.rd_value;
        end
        if (!entries[i].rs2_rdy && entries[i].rs2_phy == cdb.rd_phy) begin
          entries[i].rs2_rdy   <= 1'b1;
          entries[i].rs2_value <= cdb.rd_value;
        end
      end
    end
  end

endmodule
